feature_frame_loader: RTL and testbench
=======================================

Name: feature_frame_loader

Overview:
- Producer end of the feature-vector interface consumed by the combinational classifier trees.
- Receives a byte stream with valid/ready/last framing and assembles each frame into a FEAT_W-bit feature vector.
- Presents each completed vector through a registered valid/ready output, so all trees sample one stable vector per transfer.
- Double-buffered: an assembly register plus an output register, so a new frame can load while the previous vector waits for the consumer.

Parameters:
- FEAT_W, 51: feature vector width. Bit k drives tree input i[k].
- IN_W, 8: input beat width.
- BEATS, derived as ceil(FEAT_W/IN_W), 7 at the defaults: beats per legal frame. Not overridable.
- CNT_W, 16: width of the accepted-frame counter.

Ports:
- clk  input  1  Single clock. All logic is rising-edge.
- rst_n  input  1  Asynchronous active-low reset. Release is synchronised externally.
- s_valid  input  1  Input beat valid.
- s_ready  output  1  Loader can accept a beat.
- s_data  input  IN_W  Input beat.
- s_last  input  1  Final beat of the frame.
- m_valid  output  1  m_feat holds a complete vector.
- m_ready  input  1  Consumer accepts the vector.
- m_feat  output  FEAT_W  Assembled feature vector, registered.
- len_err  output  1  One-cycle pulse when a frame is discarded for wrong length.
- frame_cnt  output  CNT_W  Count of vectors delivered on the output. Wraps.

Behaviour:
- Reset (async, rst_n=0): all of the following clear immediately.
  - State = COLLECT, beat index = 0.
  - Assembly register = 0, m_feat = 0, m_valid = 0.
  - len_err = 0, frame_cnt = 0.
  - s_ready = 1 after the first clk edge following reset release.
- Beat handshake: a beat is accepted when s_valid & s_ready at a rising edge. An output transfer occurs when m_valid & m_ready.
- Packing: beat n writes assembly bits [n*IN_W +: IN_W], LSB-first. Bits at or beyond FEAT_W in the last beat are dropped (bits 55:51 at the defaults).
- COLLECT state:
  - Accepted beat with s_last=1 and index = BEATS-1: frame complete.
    - If the output register is empty, or is being drained this cycle, copy the assembly register (including this beat) to m_feat. Set m_valid=1 next cycle. Index returns to 0.
    - Otherwise go to HOLD.
  - Accepted beat with s_last=1 and index < BEATS-1: discard the frame, pulse len_err next cycle, index = 0, remain in COLLECT.
  - Accepted beat with s_last=0 and index = BEATS-1: go to DISCARD.
  - Any other accepted beat: index increments.
- HOLD state:
  - s_ready=0.
  - When the output register is empty, or a transfer occurs this cycle, copy the assembly register to m_feat, keep m_valid=1, return to COLLECT with index 0.
- DISCARD state:
  - s_ready=1. Accepted beats are dropped.
  - On an accepted beat with s_last=1: pulse len_err, return to COLLECT with index 0.
- s_ready is 1 in COLLECT and DISCARD, and 0 in HOLD. It is a registered state decode with no combinational path from m_ready.
- Output side:
  - m_feat is stable while m_valid=1 and m_ready=0.
  - On a transfer with no reload in the same cycle, m_valid clears next cycle.
  - Transfer and reload in the same cycle: m_valid stays 1 and m_feat updates. This gives back-to-back vectors with zero bubble.
- frame_cnt increments by 1 on every output transfer and wraps from 2^CNT_W-1 to 0.
- Latency: m_valid rises one cycle after the accepted last beat when the output register is free. Sustained throughput is one vector per BEATS cycles.
- Stale data: the assembly register is not cleared between frames. Every bit below FEAT_W is overwritten by a legal frame.
- Reset mid-frame or mid-HOLD: the partial frame and any pending vector are lost. No len_err is raised.

Test Plan:
- Single frame: 7 beats 0x01,0x02,...,0x07 with last on beat 7, m_ready=1 → m_valid=1 one cycle after beat 7, m_feat=51'h7_0605_0403_0201 (pad bits dropped), frame_cnt=1.
- Back-pressure: m_ready=0, send two legal frames → first vector held stable; s_ready=0 after the second frame's last beat. Raise m_ready → both vectors delivered in order on consecutive cycles, frame_cnt=2.
- Short frame: s_last on beat 4 → len_err one-cycle pulse, m_valid stays 0. The next legal frame is delivered correctly.
- Long frame: 9 beats with last on beat 9 → no output, len_err pulses once after beat 9, state returns to COLLECT.
- Reset during HOLD: assert rst_n=0 asynchronously between edges → m_valid=0, m_feat=0, frame_cnt=0 immediately, with no clock required.
- Counter wrap: preload by streaming 65536 legal frames with m_ready=1 → frame_cnt returns to 0. Streaming continuously gives m_valid high every 7th cycle.

Source files
------------

// File: rtl/feature_frame_loader.sv
// rtl/feature_frame_loader.sv - byte-stream to feature-vector loader with double buffering
module feature_frame_loader #(
    parameter int FEAT_W = 51,
    parameter int IN_W   = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [IN_W-1:0]   s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [FEAT_W-1:0] m_feat,
    output logic              len_err,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int BEATS = (FEAT_W + IN_W - 1) / IN_W;
    localparam int ASM_W = BEATS * IN_W;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    typedef enum logic [1:0] {
        COLLECT,
        HOLD,
        DISCARD
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ASM_W-1:0]    asm_q, asm_d;
    logic [FEAT_W-1:0]   m_feat_q, m_feat_d;
    logic                m_valid_q, m_valid_d;
    logic                s_ready_q, s_ready_d;
    logic                len_err_q, len_err_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;

    logic beat_acc;
    logic xfer;
    logic out_free;
    logic load;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        m_feat_d    = m_feat_q;
        m_valid_d   = m_valid_q;
        frame_cnt_d = frame_cnt_q;
        len_err_d   = 1'b0;
        load        = 1'b0;

        beat_acc = s_valid & s_ready_q;
        xfer     = m_valid_q & m_ready;
        // The output register counts as free in the same cycle it is drained.
        out_free = ~m_valid_q | m_ready;

        if (xfer) begin
            m_valid_d   = 1'b0;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end

        case (state_q)
            COLLECT: begin
                if (beat_acc) begin
                    asm_d[idx_q*IN_W +: IN_W] = s_data;
                    if (s_last && (idx_q == LAST_IDX)) begin
                        if (out_free) begin
                            load  = 1'b1;
                            idx_d = '0;
                        end else begin
                            state_d = HOLD;
                        end
                    end else if (s_last) begin
                        len_err_d = 1'b1;
                        idx_d     = '0;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = DISCARD;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_free) begin
                    load    = 1'b1;
                    state_d = COLLECT;
                    idx_d   = '0;
                end
            end
            DISCARD: begin
                if (beat_acc && s_last) begin
                    len_err_d = 1'b1;
                    state_d   = COLLECT;
                    idx_d     = '0;
                end
            end
            default: begin
                state_d = COLLECT;
                idx_d   = '0;
            end
        endcase

        // Pad bits of the final beat above FEAT_W are dropped here.
        if (load) begin
            m_feat_d  = asm_d[FEAT_W-1:0];
            m_valid_d = 1'b1;
        end

        s_ready_d = (state_d != HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            idx_q       <= '0;
            asm_q       <= '0;
            m_feat_q    <= '0;
            m_valid_q   <= 1'b0;
            s_ready_q   <= 1'b0;
            len_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            m_feat_q    <= m_feat_d;
            m_valid_q   <= m_valid_d;
            s_ready_q   <= s_ready_d;
            len_err_q   <= len_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_feat    = m_feat_q;
    assign len_err   = len_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_feature_frame_loader.sv
// tb/tb_feature_frame_loader.sv - scoreboard bench for feature_frame_loader
module tb_feature_frame_loader;

    localparam int FEAT_W = 51;
    localparam int IN_W   = 8;
    localparam int CNT_W  = 10;

    localparam logic [FEAT_W-1:0] V_SINGLE = 51'h7_0605_0403_0201;
    localparam logic [FEAT_W-1:0] V_A      = 51'h7_1615_1413_1211;
    localparam logic [FEAT_W-1:0] V_B      = 51'h6_A5A4_A3A2_A1A0;
    localparam logic [FEAT_W-1:0] V_ONES   = 51'h7_FFFF_FFFF_FFFF;
    localparam logic [FEAT_W-1:0] V_50     = 51'h6_5554_5352_5150;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [IN_W-1:0]   s_data = '0;
    logic              s_last = 1'b0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [FEAT_W-1:0] m_feat;
    logic              len_err;
    logic [CNT_W-1:0]  frame_cnt;

    feature_frame_loader #(
        .FEAT_W (FEAT_W),
        .IN_W   (IN_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_feat    (m_feat),
        .len_err   (len_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [FEAT_W-1:0] sb[$];
    logic [CNT_W-1:0]  exp_cnt = '0;
    int err_seen = 0;
    int err_exp  = 0;
    int cyc      = 0;
    int last_xfer = -1;
    bit check_gap = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every output transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (len_err) err_seen++;
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_vector: got %0h expected none", m_feat);
                end else begin
                    chk("m_feat", 64'(m_feat), 64'(sb.pop_front()));
                end
                chk("frame_cnt_at_xfer", 64'(frame_cnt), 64'(exp_cnt));
                exp_cnt++;
                if (check_gap && last_xfer >= 0) chk("xfer_gap", 64'(cyc - last_xfer), 64'd7);
                last_xfer = cyc;
            end
        end
    end

    task automatic send_beat(input logic [IN_W-1:0] d, input logic l);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        do begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            n++;
        end while (!ok && n < 50);
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_beat_timeout: got s_ready=0 expected 1");
        end
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_seq(input logic [IN_W-1:0] b0, input int n, input int inc);
        for (int i = 0; i < n; i++) send_beat(b0 + IN_W'(i * inc), i == n - 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_feat", 64'(m_feat), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_len_err", 64'(len_err), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("s_ready_after_rst", 64'(s_ready), 64'd1);

        // Single frame
        m_ready = 1'b1;
        sb.push_back(V_SINGLE);
        send_seq(8'h01, 7, 1);
        @(negedge clk);
        chk("latency_m_valid", 64'(m_valid), 64'd1);
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;
        chk("single_m_valid_clear", 64'(m_valid), 64'd0);
        chk("single_frame_cnt", 64'(frame_cnt), 64'd1);

        // Back-pressure
        m_ready = 1'b0;
        sb.push_back(V_A);
        sb.push_back(V_B);
        send_seq(8'h11, 7, 1);
        send_seq(8'hA0, 7, 1);
        @(negedge clk);
        chk("hold_s_ready", 64'(s_ready), 64'd0);
        chk("held_vector", 64'(m_feat), 64'(V_A));
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("held_vector_stable", 64'(m_feat), 64'(V_A));
        chk("hold_s_ready_stable", 64'(s_ready), 64'd0);
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_m_valid", 64'(m_valid), 64'd1);
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_frame_cnt", 64'(frame_cnt), 64'd3);
        chk("bp_s_ready", 64'(s_ready), 64'd1);

        // Short frame then legal frame
        send_seq(8'h31, 4, 1);
        err_exp++;
        repeat (2) @(posedge clk);
        #1;
        chk("short_m_valid", 64'(m_valid), 64'd0);
        chk("short_len_err", 64'(err_seen), 64'(err_exp));
        sb.push_back(V_ONES);
        send_seq(8'hFF, 7, 0);

        // Long frame then legal frame
        send_seq(8'h40, 9, 1);
        err_exp++;
        repeat (2) @(posedge clk);
        #1;
        chk("long_len_err", 64'(err_seen), 64'(err_exp));
        sb.push_back(V_50);
        send_seq(8'h50, 7, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("long_frame_cnt", 64'(frame_cnt), 64'd5);

        // Asynchronous reset while in HOLD
        m_ready = 1'b0;
        send_seq(8'h61, 7, 1);
        send_seq(8'h71, 7, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_m_valid", 64'(m_valid), 64'd0);
        chk("async_rst_m_feat", 64'(m_feat), 64'd0);
        chk("async_rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("async_rst_s_ready", 64'(s_ready), 64'd0);
        exp_cnt = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_s_ready", 64'(s_ready), 64'd1);
        chk("post_rst_m_valid", 64'(m_valid), 64'd0);
        chk("post_rst_len_err_cnt", 64'(err_seen), 64'(err_exp));

        // Continuous streaming through counter wrap
        m_ready = 1'b1;
        last_xfer = -1;
        check_gap = 1'b1;
        for (int f = 0; f < (1 << CNT_W); f++) begin
            sb.push_back(V_SINGLE);
            send_seq(8'h01, 7, 1);
        end
        repeat (3) @(posedge clk);
        #1;
        check_gap = 1'b0;
        chk("wrap_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("final_len_err_cnt", 64'(err_seen), 64'(err_exp));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
